// File: rtl/div_ctrl_pkg.sv
// Shared widths, state encodings and strobe levels for the divide sequencer.
package div_ctrl_pkg;

    localparam int unsigned RegBus       = 32;
    localparam int unsigned DoubleRegBus = 64;
    localparam int unsigned WorkW        = DoubleRegBus + 1;
    localparam int unsigned CntW         = 6;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Two's complement negate when neg is set, pass-through otherwise.
    function automatic logic [RegBus-1:0] cond_neg(input logic neg, input logic [RegBus-1:0] v);
        return neg ? (~v + RegBus'(1)) : v;
    endfunction

endpackage

// File: rtl/div_ctrl_step.sv
// One restoring shift-subtract iteration on the {partial remainder, dividend} register.
module div_step
    import div_ctrl_pkg::*;
(
    input  logic [WorkW-2:0]  work,
    input  logic [RegBus-1:0] divisor,
    output logic [WorkW-1:0]  next
);

    logic [RegBus:0] trial;

    assign trial = {1'b0, work[WorkW-2:RegBus]} - {1'b0, divisor};

    // trial[RegBus] is the borrow: on borrow the remainder is kept and a 0 shifted in.
    always_comb begin
        if (trial[RegBus]) begin
            next = {work, 1'b0};
        end else begin
            next = {trial[RegBus-1:0], work[RegBus-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit DIV/DIVU sequencer with pipeline stall request.
// Optional: define DIV_EARLY_OUT_EN to short-cut a zero dividend through the BYZERO path.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    annul_i,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o,
    output logic                    stall_req_o
);

    div_state_e              state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [WorkW-1:0]        work_q, work_d;
    logic [RegBus-1:0]       divisor_q, divisor_d;
    logic                    neg_quot_q, neg_quot_d;
    logic                    neg_rem_q, neg_rem_d;
    logic [DoubleRegBus-1:0] result_q, result_d;
    logic                    ready_q, ready_d;

    logic [WorkW-1:0]  step_next;
    logic [RegBus-1:0] abs1, abs2;
    logic              zero_path;

    div_step u_step (
        .work    (work_q[WorkW-2:0]),
        .divisor (divisor_q),
        .next    (step_next)
    );

    assign abs1 = cond_neg(signed_div_i & opdata1_i[RegBus-1], opdata1_i);
    assign abs2 = cond_neg(signed_div_i & opdata2_i[RegBus-1], opdata2_i);

`ifdef DIV_EARLY_OUT_EN
    assign zero_path = (opdata2_i == ZeroWord) || (opdata1_i == ZeroWord);
`else
    assign zero_path = (opdata2_i == ZeroWord);
`endif

    assign stall_req_o = start_i & ~annul_i & (state_q != DivEnd);
    assign result_o    = result_q;
    assign ready_o     = ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            DivFree: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    work_d     = {ZeroWord, abs1, 1'b0};
                    divisor_d  = abs2;
                    neg_quot_d = signed_div_i & (opdata1_i[RegBus-1] ^ opdata2_i[RegBus-1]);
                    neg_rem_d  = signed_div_i & opdata1_i[RegBus-1];
                    cnt_d      = '0;
                    state_d    = zero_path ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else begin
                    state_d  = DivEnd;
                    result_d = '0;
                    ready_d  = DivResultReady;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else begin
                    work_d = step_next;
                    cnt_d  = cnt_q + CntW'(1);
                    // Last iteration: register sign-corrected {remainder, quotient}.
                    if (cnt_q == CntW'(RegBus - 1)) begin
                        state_d  = DivEnd;
                        result_d = {cond_neg(neg_rem_q, step_next[WorkW-1:RegBus+1]),
                                    cond_neg(neg_quot_q, step_next[RegBus-1:0])};
                        ready_d  = DivResultReady;
                    end
                end
            end
            DivEnd: begin
                if (annul_i || start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end
            default: begin
                state_d  = DivFree;
                result_d = '0;
                ready_d  = DivResultNotReady;
            end
        endcase
    end

endmodule
